// File: rtl/vram_scan_arbiter_if.sv
// Bundles scan-control, client A/B, SRAM and line-buffer signals of the VRAM arbiter.
// Latency: none (wiring only).
// Backpressure: clients hold *_req until *_gnt; the SRAM side never stalls.
interface vram_scan_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    // scan generator
    logic              frame_start;
    logic              line_start;
    logic              line_active;
    // client A
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    // client B
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    // shared client read data
    logic [DATA_W-1:0] c_rdata;
    // SRAM
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // line buffer
    logic              lb_we;
    logic [6:0]        lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    // status
    logic              overrun;

    // arbiter side: owns the SRAM port, the line buffer and the grants
    modport master (
        input  frame_start, line_start, line_active,
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, c_rdata,
        output mem_addr, mem_we, mem_wdata,
        output lb_we, lb_waddr, lb_wdata,
        output overrun
    );

    // environment side: scan generator, clients, SRAM and line buffer
    modport slave (
        output frame_start, line_start, line_active,
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, c_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  lb_we, lb_waddr, lb_wdata,
        input  overrun
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares one single-port framebuffer SRAM between line-fetch bursts (top priority) and round-robin clients A/B.
// Latency: client grant same cycle, read data 1 cycle after grant; line_start to first lb_we 2 cycles.
// Backpressure: clients hold req until gnt and wait out a LINE_WORDS-cycle burst; bursts never stall.
module vram_scan_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 80,
    parameter int LINES      = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    vram_scan_arbiter_if.master bus
);
    localparam int WIDX_W = 7;
    localparam int LIDX_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(LINE_WORDS - 1);
    localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(LINES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDX_W-1:0]   word_idx;
    logic [LIDX_W-1:0]   line_idx;
    logic                frame_pend;   // frame_start seen mid-burst: zero line_idx at burst end
    logic                last_was_a;   // round-robin pointer: 1 = A was granted most recently
    logic                start_fetch;
    logic                last_issue;
    logic                fetch_issue;
    logic                a_gnt_c;
    logic                b_gnt_c;
    logic                lb_we_q;
    logic [WIDX_W-1:0]   lb_waddr_q;
    logic                a_rvalid_q;
    logic                b_rvalid_q;
    logic                overrun_q;
    logic [ADDR_W-1:0]   fetch_addr;

    assign start_fetch = (state == IDLE) && bus.line_start && bus.line_active;
    assign last_issue  = (state == FETCH) && (word_idx == LAST_WORD);
    // multiply in ADDR_W bits so the result wraps exactly like the truncated address
    assign fetch_addr  = ADDR_W'(line_idx) * ADDR_W'(LINE_WORDS) + ADDR_W'(word_idx);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: enter FETCH on a visible line_start, leave after the last word is issued
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_fetch) state_nxt = FETCH;
            FETCH:   if (word_idx == LAST_WORD) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: burst read in FETCH, otherwise round-robin client grant driving the SRAM port
    always_comb begin
        a_gnt_c       = 1'b0;
        b_gnt_c       = 1'b0;
        fetch_issue   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        case (state)
            FETCH: begin
                fetch_issue  = 1'b1;
                bus.mem_addr = fetch_addr;
            end
            default: begin
                // the cycle that launches a burst is left idle for clients
                if (rst_n && !start_fetch) begin
                    if (bus.a_req && (!bus.b_req || !last_was_a)) begin
                        a_gnt_c = 1'b1;
                    end else if (bus.b_req) begin
                        b_gnt_c = 1'b1;
                    end
                end
            end
        endcase
        if (a_gnt_c) begin
            bus.mem_addr  = bus.a_addr;
            bus.mem_we    = bus.a_we;
            bus.mem_wdata = bus.a_wdata;
        end else if (b_gnt_c) begin
            bus.mem_addr  = bus.b_addr;
            bus.mem_we    = bus.b_we;
            bus.mem_wdata = bus.b_wdata;
        end
    end

    // burst word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
        end else if (state == FETCH) begin
            word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + WIDX_W'(1);
        end else begin
            word_idx <= '0;
        end
    end

    // line index: advance after each burst, zero on frame_start (deferred to burst end while fetching)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_idx   <= '0;
            frame_pend <= 1'b0;
        end else begin
            frame_pend <= (state == FETCH) && !last_issue && (frame_pend || bus.frame_start);
            if (last_issue) begin
                if (frame_pend || bus.frame_start || line_idx == LAST_LINE) begin
                    line_idx <= '0;
                end else begin
                    line_idx <= line_idx + LIDX_W'(1);
                end
            end else if (state == IDLE && bus.frame_start) begin
                line_idx <= '0;
            end
        end
    end

    // line-buffer write one cycle behind each burst read, when the SRAM data arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_we_q    <= 1'b0;
            lb_waddr_q <= '0;
        end else begin
            lb_we_q    <= fetch_issue;
            lb_waddr_q <= fetch_issue ? word_idx : '0;
        end
    end

    // client read-data valid one cycle after a read grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_gnt_c && !bus.a_we;
            b_rvalid_q <= b_gnt_c && !bus.b_we;
        end
    end

    // round-robin pointer and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_a <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (a_gnt_c) begin
                last_was_a <= 1'b1;
            end else if (b_gnt_c) begin
                last_was_a <= 1'b0;
            end
            if (state == FETCH && bus.line_start) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.a_gnt    = a_gnt_c;
    assign bus.b_gnt    = b_gnt_c;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.c_rdata  = (a_rvalid_q || b_rvalid_q) ? bus.mem_rdata : '0;
    assign bus.lb_we    = lb_we_q;
    assign bus.lb_waddr = lb_waddr_q;
    assign bus.lb_wdata = lb_we_q ? bus.mem_rdata : '0;
    assign bus.overrun  = overrun_q;

endmodule
